// File: rtl/r200fetchctl_if.sv
// r200fetchctl_if: fetch-control bundle between the r200 sequencing controller
// and the fetch / IF-ID stages.
//   Requests into the controller : br_taken, jump, stall_req, halt, pc_cur[31:0]
//   Controls out of the controller: pcsel[1:0], pc_hold[31:0], pc_rst,
//                                   ifid_en, ifid_flush, halted
//   Performance counters          : stall_cnt, redirect_cnt [CNTW-1:0]
// Modport master is the controller side; slave is the pipeline side.
interface r200fetchctl_if #(
  parameter int unsigned CNTW = 16
);
  logic            br_taken;
  logic            jump;
  logic            stall_req;
  logic            halt;
  logic [31:0]     pc_cur;
  logic [1:0]      pcsel;
  logic [31:0]     pc_hold;
  logic            pc_rst;
  logic            ifid_en;
  logic            ifid_flush;
  logic            halted;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] redirect_cnt;

  modport master (
    input  br_taken, jump, stall_req, halt, pc_cur,
    output pcsel, pc_hold, pc_rst, ifid_en, ifid_flush, halted,
           stall_cnt, redirect_cnt
  );

  modport slave (
    output br_taken, jump, stall_req, halt, pc_cur,
    input  pcsel, pc_hold, pc_rst, ifid_en, ifid_flush, halted,
           stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/r200fetchctl.sv
// r200fetchctl: sequencing controller for the r200 instruction-fetch stage.
// Arbitrates boot, branch/jump redirects, hazard stalls and halt, and keeps
// saturating stall/redirect counters.
//   clk  : system clock, all state on rising edge
//   rst  : synchronous, active-low reset
//   bus  : r200fetchctl_if.master (requests in, PC-select / IF-ID controls and
//          counters out)
module r200fetchctl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNTW         = 16
) (
  input  logic           clk,
  input  logic           rst,
  r200fetchctl_if.master bus
);

  localparam int unsigned BW = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   boot_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [CNTW-1:0] stall_q;
  logic [CNTW-1:0] redirect_q;

  logic            redirect;
  logic            stall_hit;
  logic [1:0]      pcsel;
  logic            ifid_en;
  logic            ifid_flush;

  // Only RUN acts on requests; halt outranks redirects, which outrank stalls.
  always_comb begin
    redirect  = 1'b0;
    stall_hit = 1'b0;
    if (state == RUN && !bus.halt) begin
      redirect  = bus.br_taken || bus.jump;
      stall_hit = !redirect && bus.stall_req;
    end
  end

  // State register and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BOOT;
      boot_cnt   <= BW'(BOOT_CYCLES - 1);
      flush_cnt  <= '0;
      stall_q    <= '0;
      redirect_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == BOOT && boot_cnt != '0)
        boot_cnt <= boot_cnt - 1'b1;
      if (redirect)
        flush_cnt <= FW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
      if (stall_hit && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (redirect && redirect_q != '1)
        redirect_q <= redirect_q + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:  if (boot_cnt == '0) state_nxt = RUN;
      RUN: begin
        if (bus.halt)                     state_nxt = HALT;
        else if (bus.br_taken || bus.jump) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (bus.halt)            state_nxt = HALT;
        else if (flush_cnt == '0) state_nxt = RUN;
      end
      HALT:  state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    pcsel      = 2'b00;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    case (state)
      BOOT: begin
        pcsel      = 2'b00;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
      end
      RUN: begin
        if (bus.halt) begin
          pcsel      = 2'b11;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
        end else if (bus.br_taken) begin
          pcsel      = 2'b01;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else if (bus.jump) begin
          pcsel      = 2'b10;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else if (bus.stall_req) begin
          pcsel      = 2'b11;
          ifid_en    = 1'b0;
          ifid_flush = 1'b0;
        end else begin
          pcsel      = 2'b00;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
        end
      end
      FLUSH: begin
        if (bus.halt) begin
          pcsel      = 2'b11;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
        end else begin
          pcsel      = 2'b00;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end
      end
      HALT: begin
        pcsel      = 2'b11;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcsel        = pcsel;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.pc_hold      = bus.pc_cur;
  assign bus.pc_rst       = (state == BOOT);
  assign bus.halted       = (state == HALT);
  assign bus.stall_cnt    = stall_q;
  assign bus.redirect_cnt = redirect_q;

endmodule

// File: tb/tb_r200fetchctl.sv
// tb_r200fetchctl: self-checking bench for r200fetchctl with directed scenarios
// followed by randomized requests, compared every cycle to a cycle-count
// reference model of the fetch controller.
module tb_r200fetchctl;

  localparam int unsigned BOOT_CYCLES  = 2;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNTW         = 4;
  localparam int          CMAX         = (1 << CNTW) - 1;

  logic clk;
  logic rst;

  r200fetchctl_if #(.CNTW(CNTW)) bus ();

  r200fetchctl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNTW        (CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining boot/flush cycles, halt flag, event counts.
  bit model_valid = 0;
  int boot_left;
  int flush_left;
  bit m_halt;
  int m_stall;
  int m_redir;

  task automatic model_reset();
    boot_left   = BOOT_CYCLES;
    flush_left  = 0;
    m_halt      = 0;
    m_stall     = 0;
    m_redir     = 0;
    model_valid = 1;
  endtask

  // One clock: drive inputs, check combinational/registered outputs, clock, update model.
  task automatic step(input bit r, input bit b, input bit j, input bit s,
                      input bit h, input logic [31:0] pc);
    logic [1:0] e_sel;
    bit e_en, e_fl, e_rst, e_hlt;
    rst           = r;
    bus.br_taken  = b;
    bus.jump      = j;
    bus.stall_req = s;
    bus.halt      = h;
    bus.pc_cur    = pc;
    #1;
    if (model_valid) begin
      e_rst = 0; e_hlt = 0;
      if (boot_left > 0) begin
        e_sel = 2'b00; e_en = 0; e_fl = 1; e_rst = 1;
      end else if (m_halt) begin
        e_sel = 2'b11; e_en = 0; e_fl = 1; e_hlt = 1;
      end else if (h) begin
        e_sel = 2'b11; e_en = 0; e_fl = 1;
      end else if (flush_left > 0) begin
        e_sel = 2'b00; e_en = 1; e_fl = 1;
      end else if (b) begin
        e_sel = 2'b01; e_en = 1; e_fl = 1;
      end else if (j) begin
        e_sel = 2'b10; e_en = 1; e_fl = 1;
      end else if (s) begin
        e_sel = 2'b11; e_en = 0; e_fl = 0;
      end else begin
        e_sel = 2'b00; e_en = 1; e_fl = 0;
      end
      check("pcsel",        32'(bus.pcsel),        32'(e_sel));
      check("ifid_en",      32'(bus.ifid_en),      32'(e_en));
      check("ifid_flush",   32'(bus.ifid_flush),   32'(e_fl));
      check("pc_rst",       32'(bus.pc_rst),       32'(e_rst));
      check("halted",       32'(bus.halted),       32'(e_hlt));
      check("pc_hold",      bus.pc_hold,           pc);
      check("stall_cnt",    32'(bus.stall_cnt),    32'(m_stall));
      check("redirect_cnt", 32'(bus.redirect_cnt), 32'(m_redir));
    end
    @(posedge clk);
    if (!r) model_reset();
    else if (model_valid) begin
      if (boot_left > 0)       boot_left--;
      else if (m_halt)         ;
      else if (h)              begin m_halt = 1; flush_left = 0; end
      else if (flush_left > 0) flush_left--;
      else if (b || j) begin
        if (m_redir < CMAX) m_redir++;
        flush_left = FLUSH_CYCLES;
      end else if (s) begin
        if (m_stall < CMAX) m_stall++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 32'h100 + 32'(4 * i));
  endtask

  initial begin
    rst = 1'b0;
    bus.br_taken = 0; bus.jump = 0; bus.stall_req = 0; bus.halt = 0;
    bus.pc_cur = '0;

    // Reset held three cycles, then boot and idle run
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0);
    idle(4);

    // Single taken branch, then branch+jump+stall together, jump during flush
    step(1, 1, 0, 0, 0, 32'h200);
    idle(3);
    step(1, 1, 1, 1, 0, 32'h204);
    step(1, 0, 1, 0, 0, 32'h208);
    step(1, 0, 1, 1, 0, 32'h20c);
    idle(2);

    // Three-cycle stall on a fixed PC, then release
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 32'h40);
    check("stall_cnt_after3", 32'(bus.stall_cnt), 32'd3);
    idle(2);

    // Halt during flush, requests afterwards ignored, reset recovers
    step(1, 0, 1, 0, 0, 32'h300);
    step(1, 0, 0, 0, 1, 32'h304);
    step(1, 1, 1, 1, 0, 32'h308);
    step(1, 0, 0, 1, 1, 32'h30c);
    check("halted_hold", 32'(bus.halted), 32'd1);
    step(0, 0, 0, 0, 0, 32'h310);
    check("halted_after_rst", 32'(bus.halted), 32'd0);
    idle(3);

    // Saturation: 20 stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, 32'h400);
    check("stall_sat", 32'(bus.stall_cnt), 32'(CMAX));
    idle(2);

    // Randomized requests, including occasional mid-sequence resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 79) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 59) == 0),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r200fetchctl.md
Name: r200fetchctl

Overview:
- Sequencing controller for the r200 instruction-fetch stage.
- Drives the fetch stage's 2-bit PC-select, PC reset and hold-address inputs.
- Drives IF/ID register enable and flush.
- Arbitrates boot, branch/jump redirects, hazard stalls and halt, with saturating performance counters for stalls and redirects.

Parameters:
- BOOT_CYCLES, 2: cycles pc_rst stays asserted after reset release (>=1).
- FLUSH_CYCLES, 1: extra squash cycles after a redirect cycle (>=1).
- CNTW, 16: width of the performance counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- br_taken  input  1  resolved taken branch from EX
- jump  input  1  decoded jump from ID
- stall_req  input  1  hazard unit requests fetch/IF-ID freeze
- halt  input  1  stop fetching until reset
- pc_cur  input  32  current PC (fetch-stage PC output)
- pcsel  output  2  00 = pc+4, 01 = branch target, 10 = jump target, 11 = hold
- pc_hold  output  32  address fed to the fetch stage's hold input; equals pc_cur (combinational)
- pc_rst  output  1  active-high reset to the PC register
- ifid_en  output  1  IF/ID pipeline register load enable
- ifid_flush  output  1  IF/ID register clear (bubble insert)
- halted  output  1  high in HALT state
- stall_cnt  output  CNTW  saturating count of stall cycles
- redirect_cnt  output  CNTW  saturating count of redirects

Behaviour:
- Reset and interface
  - Clock is clk. Reset is rst: synchronous, active-low. When rst=0 at a rising edge: state<=BOOT, boot counter<=BOOT_CYCLES-1, flush counter<=0, stall_cnt<=0, redirect_cnt<=0.
  - Reset applies from any state, mid-flush or mid-stall included; the next cycle is BOOT.
- States: BOOT, RUN, FLUSH, HALT. pcsel, ifid_en and ifid_flush are combinational from state and inputs; everything else is registered.
- BOOT
  - Outputs: pc_rst=1, pcsel=00, ifid_en=0, ifid_flush=1.
  - All requests ignored; counters not updated.
  - Boot counter decrements each cycle; at 0 go to RUN. BOOT therefore lasts exactly BOOT_CYCLES cycles.
- RUN: pc_rst=0. Per-cycle priority, highest first:
  1. halt: pcsel=11, ifid_en=0, ifid_flush=1; next HALT.
  2. br_taken: pcsel=01, ifid_en=1, ifid_flush=1, redirect_cnt++. Next FLUSH with flush counter=FLUSH_CYCLES-1. br_taken beats jump, because the branch is older.
  3. jump: pcsel=10; otherwise identical to br_taken.
  4. stall_req: pcsel=11, ifid_en=0, ifid_flush=0, stall_cnt++; stay RUN.
  5. none: pcsel=00, ifid_en=1, ifid_flush=0.
  - Redirect beats stall in the same cycle: the stalled younger instruction is squashed. stall_cnt is not incremented that cycle.
- FLUSH
  - Outputs: pcsel=00, ifid_en=1, ifid_flush=1.
  - br_taken, jump and stall_req are ignored (wrong-path instructions).
  - halt is honoured: same outputs and transition as in RUN.
  - Flush counter 0 -> RUN, else decrement. FLUSH lasts exactly FLUSH_CYCLES cycles.
- HALT
  - Outputs: pcsel=11, ifid_en=0, ifid_flush=1, halted=1, pc_rst=0.
  - Exit only via reset. No counters update.
- halted=0 in all other states.
- Counters: saturate at all-ones, no wrap.
- pc_hold=pc_cur always, so pcsel=11 reloads the same PC.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> pc_rst=1 for exactly 2 cycles, ifid_flush=1 during them. Then RUN with pcsel=00, ifid_en=1, counters 0.
- Taken branch: in RUN pulse br_taken 1 cycle -> pcsel=01 and ifid_flush=1 that cycle. Next cycle FLUSH: pcsel=00, ifid_flush=1. Then RUN. redirect_cnt=1.
- Branch and jump together, plus stall_req -> pcsel=01, redirect_cnt=1, stall_cnt=0. A jump asserted during the following FLUSH cycle is ignored: pcsel=00, redirect_cnt stays 1.
- Stall for 3 cycles with pc_cur=0x00000040 -> pcsel=11, pc_hold=0x40, ifid_en=0, ifid_flush=0, stall_cnt=3. Release -> pcsel=00, ifid_en=1.
- Halt during FLUSH -> HALT, halted=1, pcsel=11. br_taken, stall_req and jump then have no effect. rst=0 -> BOOT, halted=0.
- Saturation: CNTW=4, stall 20 cycles -> stall_cnt=15 and holds.
